// File: rtl/ahbl_trace_capture.sv
// rtl/ahbl_trace_capture.sv - passive AHB-Lite transfer tracer with record FIFO
module ahbl_trace_capture #(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [1:0]             ahbl_htrans_i,
  input  logic [31:0]            ahbl_haddr_i,
  input  logic                   ahbl_hwrite_i,
  input  logic [31:0]            ahbl_hwdata_i,
  input  logic [31:0]            ahbl_hrdata_i,
  input  logic                   ahbl_hreadyout_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [TS_W-1:0]        trace_tstamp_o,
  output logic [31:0]            trace_addr_o,
  output logic [31:0]            trace_data_o,
  output logic                   trace_write_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic [DROP_W-1:0]      drop_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = TS_W + 65;

  logic [TS_W-1:0]   tstamp_q;
  logic              pending_q;
  logic              pwrite_q;
  logic [31:0]       paddr_q;
  logic [RW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [DROP_W-1:0] drop_q;
  logic              accept;
  logic              complete;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [RW-1:0]     rec;
  logic              unused_htrans0;

  // only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
  assign unused_htrans0 = ahbl_htrans_i[0];

  assign accept   = enable_i && ahbl_htrans_i[1] && ahbl_hreadyout_i;
  assign complete = pending_q && ahbl_hreadyout_i;
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = trace_valid_o && trace_ready_i;
  assign push     = complete && (!full || pop);
  assign drop     = complete && full && !pop;
  assign rec      = {tstamp_q, paddr_q, (pwrite_q ? ahbl_hwdata_i : ahbl_hrdata_i), pwrite_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tstamp_q  <= '0;
      pending_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
    end else begin
      tstamp_q <= tstamp_q + TS_W'(1);
      if (accept) begin
        pending_q <= 1'b1;
        paddr_q   <= ahbl_haddr_i;
        pwrite_q  <= ahbl_hwrite_i;
      end else if (complete) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
      if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
    end
  end

  // storage needs no reset; occupancy tracking masks stale entries
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= rec;
  end

  assign trace_valid_o = (level_q != '0);
  assign {trace_tstamp_o, trace_addr_o, trace_data_o, trace_write_o} =
    trace_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o  = level_q;
  assign drop_count_o  = drop_q;
endmodule

// File: tb/tb_ahbl_trace_capture.sv
// tb/tb_ahbl_trace_capture.sv - self-checking bench for ahbl_trace_capture
module tb_ahbl_trace_capture;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int DROP_W = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, enable, hwrite, hready, ready;
  logic [1:0]        htrans;
  logic [31:0]       haddr, hwdata, hrdata;
  logic              valid, write;
  logic [TS_W-1:0]   tstamp;
  logic [31:0]       addr, data;
  logic [LW-1:0]     level;
  logic [DROP_W-1:0] drops;

  always #5 clk = ~clk;

  ahbl_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .ahbl_htrans_i(htrans), .ahbl_haddr_i(haddr), .ahbl_hwrite_i(hwrite),
    .ahbl_hwdata_i(hwdata), .ahbl_hrdata_i(hrdata), .ahbl_hreadyout_i(hready),
    .trace_valid_o(valid), .trace_ready_i(ready), .trace_tstamp_o(tstamp),
    .trace_addr_o(addr), .trace_data_o(data), .trace_write_o(write),
    .fifo_level_o(level), .drop_count_o(drops)
  );

  typedef struct {
    logic [TS_W-1:0] ts;
    logic [31:0]     a;
    logic [31:0]     d;
    logic            w;
  } rec_t;

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        ready;
    logic        e_valid;
    logic [4:0]  e_level;
    logic [31:0] e_ts;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_write;
  } vec_t;

  rec_t              mq[$];
  logic [TS_W-1:0]   m_ts;
  logic              m_pend, m_write;
  logic [31:0]       m_addr;
  logic [DROP_W-1:0] m_drop;
  int checks = 0;
  int errors = 0;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: the FIFO is a queue of whole records, applied once per clock edge
  task automatic model_edge();
    rec_t r;
    bit   pop, comp;
    if (rst) begin
      mq.delete();
      m_ts = '0; m_pend = 1'b0; m_drop = '0;
      return;
    end
    pop  = (mq.size() != 0) && ready;
    comp = m_pend && hready;
    r = '{m_ts, m_addr, (m_write ? hwdata : hrdata), m_write};
    if (pop) void'(mq.pop_front());
    if (comp) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else if (m_drop != '1) m_drop = m_drop + 1'b1;
    end
    if (enable && htrans[1] && hready) begin
      m_pend = 1'b1; m_addr = haddr; m_write = hwrite;
    end else if (comp) begin
      m_pend = 1'b0;
    end
    m_ts = m_ts + 1'b1;
  endtask

  task automatic model_check();
    chk("m_valid", 64'(valid), 64'(mq.size() != 0));
    chk("m_level", 64'(level), 64'(mq.size()));
    chk("m_drop", 64'(drops), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("m_tstamp", 64'(tstamp), 64'(mq[0].ts));
      chk("m_addr", 64'(addr), 64'(mq[0].a));
      chk("m_data", 64'(data), 64'(mq[0].d));
      chk("m_write", 64'(write), 64'(mq[0].w));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic set_bus(input logic [1:0] t, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic hr, input logic rdy);
    htrans = t; haddr = a; hwrite = w; hwdata = wd; hrdata = rd; hready = hr; ready = rdy;
  endtask

  initial begin
    int nrec;
    vecs[0] = '{2'b10, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};
    vecs[2] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 5'd1, 32'd2, 32'h100, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};
    vecs[4] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{2'b10, 32'h20000000, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};
    vecs[6] = '{2'b10, 32'h20000004, 1'b0, 32'h12345678, 32'h0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd6, 32'h20000000, 32'h12345678, 1'b1};
    vecs[7] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 5'd1, 32'd7, 32'h20000004, 32'hCAFEF00D, 1'b0};
    vecs[8] = '{2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0};

    rst = 1'b1; enable = 1'b1;
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(); cycle();
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_drop", 64'(drops), 64'(0));
    chk("rst_outs", {tstamp, addr}, 64'(0));
    rst = 1'b0;

    // single read with one wait state, then a pipelined write/read pair
    for (int i = 0; i < 9; i++) begin
      set_bus(vecs[i].htrans, vecs[i].haddr, vecs[i].hwrite, vecs[i].hwdata,
              vecs[i].hrdata, vecs[i].hready, vecs[i].ready);
      cycle();
      chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_level));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_tstamp", i), 64'(tstamp), 64'(vecs[i].e_ts));
        chk($sformatf("vec%0d_addr", i), 64'(addr), 64'(vecs[i].e_addr));
        chk($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].e_data));
        chk($sformatf("vec%0d_write", i), 64'(write), 64'(vecs[i].e_write));
      end
    end

    // overflow: DEPTH+3 back-to-back reads with no consumer
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_bus(2'b10, 32'h30000000 + 32'(i * 4), 1'b0, 32'h0, 32'h50000000 + 32'(i), 1'b1, 1'b0);
      cycle();
    end
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ovf_level", 64'(level), 64'(DEPTH));
    chk("ovf_drop", 64'(drops), 64'(3));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_addr", i), 64'(addr), 64'(32'h30000000 + 32'(i * 4)));
      set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      cycle();
    end
    chk("drain_empty", 64'(valid), 64'(0));

    // full FIFO with a pop on the same edge as a completion
    for (int i = 0; i <= DEPTH; i++) begin
      set_bus(2'b10, 32'h40000000 + 32'(i * 4), 1'b0, 32'h0, 32'(i), 1'b1, 1'b0);
      cycle();
    end
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    cycle();
    chk("fullpop_level", 64'(level), 64'(DEPTH));
    chk("fullpop_drop", 64'(drops), 64'(3));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fullpop%0d_addr", i), 64'(addr), 64'(32'h40000000 + 32'((i + 1) * 4)));
      cycle();
    end
    chk("fullpop_empty", 64'(valid), 64'(0));

    // enable drops right after an accepted write that then waits 3 cycles
    set_bus(2'b10, 32'h50000000, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_bus(2'b10, 32'h50000010, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle();
    end
    set_bus(2'b10, 32'h50000010, 1'b0, 32'hA5A50001, 32'h0, 1'b1, 1'b1);
    cycle();
    chk("gate_valid", 64'(valid), 64'(1));
    chk("gate_addr", 64'(addr), 64'(32'h50000000));
    chk("gate_data", 64'(data), 64'(32'hA5A50001));
    chk("gate_write", 64'(write), 64'(1));
    nrec = 0;
    for (int i = 0; i < 6; i++) begin
      set_bus(2'b10, 32'h50000020 + 32'(i * 4), 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      cycle();
      if (valid) nrec++;
    end
    chk("gate_norec", 64'(nrec), 64'(0));
    enable = 1'b1;
    set_bus(2'b10, 32'h50000100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    cycle();
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h77, 1'b1, 1'b1);
    cycle();
    chk("reen_addr", 64'(addr), 64'(32'h50000100));
    cycle();

    // reset with 5 queued records and a sixth transfer pending
    for (int i = 0; i < 6; i++) begin
      set_bus(2'b10, 32'h60000000 + 32'(i * 4), 1'b0, 32'h0, 32'(i), 1'b1, 1'b0);
      cycle();
    end
    chk("pre_rst_level", 64'(level), 64'(5));
    rst = 1'b1;
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    rst = 1'b0;
    chk("mrst_valid", 64'(valid), 64'(0));
    chk("mrst_level", 64'(level), 64'(0));
    chk("mrst_drop", 64'(drops), 64'(0));
    cycle(); cycle();
    chk("mrst_nopend", 64'(level), 64'(0));
    set_bus(2'b10, 32'h70000000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    set_bus(2'b00, 32'h0, 1'b0, 32'h0, 32'h11, 1'b1, 1'b0);
    cycle();
    chk("mrst_tstamp", 64'(tstamp), 64'(3));
    chk("mrst_addr", 64'(addr), 64'(32'h70000000));

    // randomized traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      set_bus(2'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
              ($urandom_range(0, 3) != 0), 1'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahbl_trace_capture.md
Name: ahbl_trace_capture

Overview:
- Synthesizable AHB-Lite transaction tracer. It taps one CPU AHB-Lite master port (instruction or data) passively, one instance per port.
- It pairs each address phase with its completing data phase and produces trace records {timestamp, address, data, direction}.
- Records are buffered in a FIFO and handed downstream over a valid/ready stream to the debug UART dumper.
- It never drives the bus.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, 2..256.
- TS_W, 32, timestamp counter width.
- DROP_W, 16, dropped-record counter width.

Ports:
- clk_i  in  1  SoC clock (clk_soc domain)
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  capture enable
- ahbl_htrans_i  in  2  tapped HTRANS
- ahbl_haddr_i  in  32  tapped HADDR
- ahbl_hwrite_i  in  1  tapped HWRITE
- ahbl_hwdata_i  in  32  tapped HWDATA
- ahbl_hrdata_i  in  32  tapped HRDATA
- ahbl_hreadyout_i  in  1  tapped HREADYOUT (bus HREADY)
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  downstream accepts record
- trace_tstamp_o  out  TS_W  cycle count at data-phase completion
- trace_addr_o  out  32  transfer address
- trace_data_o  out  32  HWDATA for writes, HRDATA for reads
- trace_write_o  out  1  1 = write, 0 = read
- fifo_level_o  out  clog2(DEPTH)+1  current occupancy
- drop_count_o  out  DROP_W  saturating count of records lost to FIFO full

Behaviour:
- Reset (rst_i=1 at a clk_i edge): FIFO empty, trace_valid_o=0, all trace_* data outputs=0, fifo_level_o=0, drop_count_o=0, timestamp=0, no pending transfer. A transfer in flight at reset is discarded.
- Timestamp: free-running, +1 every cycle out of reset, wraps modulo 2^TS_W.
- Address-phase accept: at a clk_i edge where enable_i=1, htrans_i[1]=1 (NONSEQ/SEQ) and hreadyout_i=1.
  - Latch addr and hwrite; set pending=1.
  - IDLE and BUSY are never accepted.
- Data-phase complete: first edge with pending=1 and hreadyout_i=1.
  - Form the record: data = hwdata_i if the latched write=1, else hrdata_i; tstamp = current counter value.
  - Wait states (hreadyout_i=0) hold pending; no record is produced.
- Pipelining: completion and a new address-phase accept on the same edge are legal. The new transfer becomes pending while the old one is pushed. Back-to-back single-cycle transfers produce one record per cycle.
- pending clears on completion unless a new accept occurs on that same edge.
- enable_i=0: blocks new accepts only. An already-pending transfer still completes and is recorded.
- FIFO push:
  - The record is written on the completion edge.
  - It is visible on the trace_* outputs no earlier than the next cycle (registered output, no combinational bypass from bus to trace_*).
- FIFO pop: on any edge with trace_valid_o=1 and trace_ready_i=1.
- Stream stability: trace_* outputs stay stable while trace_valid_o=1 and trace_ready_i=0.
- Full:
  - A push when level=DEPTH and no pop on the same edge drops the record; drop_count_o increments and saturates at all-ones.
  - A push and pop on the same edge when full is accepted; level stays DEPTH.
- Empty: a push and pop cannot coincide when empty (no bypass). trace_valid_o rises the cycle after the first push.
- fifo_level_o: updated on the same edge as the push/pop; equals pushes minus pops.
- Pointers wrap modulo DEPTH.

Test Plan:
- Single read: after reset, NONSEQ read addr=0x0000_0100, 1 wait state, hrdata=0xDEAD_BEEF, trace_ready_i=1 -> exactly one record {addr=0x100, data=0xDEADBEEF, write=0, tstamp = completion cycle}; trace_valid_o high for 1 cycle.
- Pipelined traffic: write 0x2000_0000/0x1234_5678 followed back-to-back by a read 0x2000_0004/0xCAFE_F00D with no waits, then IDLE, ready=1 -> two records in order, tstamps differing by 1, write flags 1 then 0.
- Overflow: ready=0, DEPTH+3 single-cycle reads -> fifo_level_o=16, drop_count_o=3. Then ready=1 -> the first 16 records drain in issue order and trace_valid_o falls.
- Full with simultaneous pop: FIFO full, ready=1 pulsed on the same edge as a completion -> level stays 16, drop_count_o unchanged, new record appears last.
- Enable gating: enable_i drops on the edge after an accepted write with 3 wait states -> that write is still recorded; subsequent NONSEQ transfers produce no records until enable_i=1.
- Reset mid-operation: rst_i asserted with 5 entries queued and a transfer pending -> next cycle trace_valid_o=0, level=0, drop_count_o=0, timestamp restarts at 0, and the pending transfer never appears.
